// File: rtl/maxpool_pkg.sv
// +--------------------------------------------------------------------------+
// | maxpool_pkg : shared types and default widths for the 2x2 max-pool ctrl  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package maxpool_pkg;

  localparam int MP_DATA_W = 16;
  localparam int MP_ADDR_W = 16;
  localparam int MP_DIM_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LAST = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef logic [1:0] slot_idx_t;

endpackage

`default_nettype wire

// File: rtl/maxpool_addr_gen.sv
// +--------------------------------------------------------------------------+
// | maxpool_addr_gen : incremental window/row/output address generation      |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module maxpool_addr_gen
  import maxpool_pkg::*;
#(
  parameter int ADDR_W = MP_ADDR_W,
  parameter int DIM_W  = MP_DIM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  slot_idx_t         step_read_i,
  input  logic              advance_window_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              last_window_o
);

  logic [DIM_W-1:0]  width_q, ow_q, oh_q, ox_q, oy_q;
  logic [ADDR_W-1:0] p_q, row_base_q, out_addr_q;
  logic [ADDR_W-1:0] w_width, w_row_step, w_next_row;
  logic              w_row_end;

  assign w_width       = ADDR_W'(width_q);
  assign w_row_step    = w_width << 1;
  assign w_next_row    = row_base_q + w_row_step;
  assign w_row_end     = (ox_q == ow_q - DIM_W'(1));
  assign last_window_o = w_row_end && (oy_q == oh_q - DIM_W'(1));
  assign out_addr_o    = out_addr_q;

  always_comb begin
    rd_addr_o = p_q;
    case (step_read_i)
      2'd0:    rd_addr_o = p_q;
      2'd1:    rd_addr_o = p_q + ADDR_W'(1);
      2'd2:    rd_addr_o = p_q + w_width;
      default: rd_addr_o = p_q + w_width + ADDR_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= '0;
      ow_q       <= '0;
      oh_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      p_q        <= '0;
      row_base_q <= '0;
      out_addr_q <= '0;
    end else if (init_i) begin
      width_q    <= width_i;
      ow_q       <= width_i >> 1;
      oh_q       <= height_i >> 1;
      ox_q       <= '0;
      oy_q       <= '0;
      p_q        <= src_base_i;
      row_base_q <= src_base_i;
      out_addr_q <= dst_base_i;
    end else if (advance_window_i) begin
      out_addr_q <= out_addr_q + ADDR_W'(1);
      if (w_row_end) begin
        // Odd trailing column is skipped by jumping straight to the next row pair.
        ox_q       <= '0;
        oy_q       <= oy_q + DIM_W'(1);
        row_base_q <= w_next_row;
        p_q        <= w_next_row;
      end else begin
        ox_q <= ox_q + DIM_W'(1);
        p_q  <= p_q + ADDR_W'(2);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/maxpool_cmp_tree.sv
// +--------------------------------------------------------------------------+
// | maxpool_cmp_tree : 4-input unsigned max, two-level comparator tree       |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module maxpool_cmp_tree #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] a1_i,
  input  logic [DATA_W-1:0] a2_i,
  input  logic [DATA_W-1:0] a3_i,
  output logic [DATA_W-1:0] max_o
);

  logic [DATA_W-1:0] w_max01;
  logic [DATA_W-1:0] w_max23;

  assign w_max01 = (a0_i >= a1_i) ? a0_i : a1_i;
  assign w_max23 = (a2_i >= a3_i) ? a2_i : a3_i;
  assign max_o   = (w_max01 >= w_max23) ? w_max01 : w_max23;

endmodule

`default_nettype wire

// File: rtl/maxpool_2x2_ctrl.sv
// +--------------------------------------------------------------------------+
// | maxpool_2x2_ctrl : sequencer for 2x2 stride-2 max pooling of one plane   |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module maxpool_2x2_ctrl
  import maxpool_pkg::*;
#(
  parameter int DATA_W = MP_DATA_W,
  parameter int ADDR_W = MP_ADDR_W,
  parameter int DIM_W  = MP_DIM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  state_e            state_q, state_d;
  slot_idx_t         phase_q, phase_d;
  logic [DATA_W-1:0] slot_q [4];
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] w_slot3, w_max;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_init, w_advance, w_last_window;

  maxpool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_i           (w_init),
    .width_i          (cfg_width),
    .height_i         (cfg_height),
    .src_base_i       (cfg_src_base),
    .dst_base_i       (cfg_dst_base),
    .step_read_i      (phase_q),
    .advance_window_i (w_advance),
    .rd_addr_o        (w_rd_addr),
    .out_addr_o       (out_addr),
    .last_window_o    (w_last_window)
  );

  // The 4th word arrives during LAST, the same edge that registers the max.
  assign w_slot3 = (state_q == ST_LAST) ? rd_data : slot_q[3];

  maxpool_cmp_tree #(
    .DATA_W (DATA_W)
  ) u_cmp_tree (
    .a0_i  (slot_q[0]),
    .a1_i  (slot_q[1]),
    .a2_i  (slot_q[2]),
    .a3_i  (w_slot3),
    .max_o (w_max)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign rd_addr   = rd_en ? w_rd_addr : '0;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rd_en     = 1'b0;
    w_init    = 1'b0;
    w_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_init  = 1'b1;
          phase_d = '0;
          if (cfg_width < DIM_W'(2) || cfg_height < DIM_W'(2)) state_d = ST_DONE;
          else                                                 state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        phase_d = phase_q + slot_idx_t'(1);
        if (phase_q == slot_idx_t'(3)) state_d = ST_LAST;
      end
      ST_LAST: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_advance = 1'b1;
          phase_d   = '0;
          state_d   = w_last_window ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      out_data_q <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (state_q == ST_READ && phase_q != slot_idx_t'(0))
        slot_q[phase_q - slot_idx_t'(1)] <= rd_data;
      if (state_q == ST_LAST) begin
        slot_q[3]  <= rd_data;
        out_data_q <= w_max;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2x2_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_maxpool_2x2_ctrl : directed scoreboard bench for maxpool_2x2_ctrl     |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_maxpool_2x2_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_height = '0;
  logic [15:0] cfg_src_base = '0;
  logic [15:0] cfg_dst_base = '0;
  logic        busy, done, rd_en, out_valid;
  logic [15:0] rd_addr, out_data, out_addr;
  logic [15:0] rd_data = '0;
  logic        out_ready = 1'b0;

  logic [15:0] mem [65536];
  logic [15:0] rdq [$];
  out_t        outq [$];
  int          checks = 0;
  int          errors = 0;

  maxpool_2x2_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input int w, input int h, input logic [15:0] src, input logic [15:0] dst);
    logic [15:0] b, mx;
    logic [15:0] a [4];
    rdq.delete();
    outq.delete();
    for (int oy = 0; oy < h / 2; oy++) begin
      for (int ox = 0; ox < w / 2; ox++) begin
        b    = src + 16'(2 * oy * w + 2 * ox);
        a[0] = b;
        a[1] = b + 16'd1;
        a[2] = b + 16'(w);
        a[3] = b + 16'(w) + 16'd1;
        mx   = 16'd0;
        for (int k = 0; k < 4; k++) begin
          rdq.push_back(a[k]);
          if (mem[a[k]] > mx) mx = mem[a[k]];
        end
        outq.push_back('{data: mx, addr: dst + 16'(oy * (w / 2) + ox)});
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_rd_en"},     rd_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_rd_addr"},   rd_addr, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_addr"},  out_addr, 0);
  endtask

  // Called at a negedge; runs one plane, optionally with backpressure on
  // output bp_out, a spurious start while busy, or a reset at iteration rst_at.
  task automatic run_plane(input int w, input int h, input logic [15:0] src, input logic [15:0] dst,
                           input int bp_out, input int bp_len, input bit busy_start, input int rst_at);
    int   i, n_acc, hold, acc_i, first_v, n_exp;
    bit   fin;
    out_t e;
    build_model(w, h, src, dst);
    n_exp = outq.size();
    i = 0; n_acc = 0; hold = 0; acc_i = -10; first_v = 0; fin = 1'b0;
    cfg_width    = 8'(w);
    cfg_height   = 8'(h);
    cfg_src_base = src;
    cfg_dst_base = dst;
    start        = 1'b1;
    while (!fin && i < 3000) begin
      @(negedge clk);
      i++;
      if (i == 1) begin
        start        = 1'b0;
        cfg_width    = 8'd3;
        cfg_height   = 8'd3;
        cfg_src_base = 16'h0000;
        cfg_dst_base = 16'h0000;
      end
      if (busy_start) start = (i == 3);
      if (rst_at != 0 && i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) begin
          @(negedge clk);
          chk("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
      chk("busy_run", busy, 1);
      chk("done_valid_excl", done & out_valid, 0);
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", rd_addr, 16'hxxxx);
        else                 chk("rd_addr", rd_addr, rdq.pop_front());
      end
      if (out_valid) begin
        if (first_v == 0) begin
          first_v = i;
          chk("first_valid_cycle", i, 6);
        end
        if (outq.size() == 0) begin
          out_ready = 1'b1;
          chk("out_unexpected", out_data, 16'hxxxx);
        end else if (n_acc == bp_out && hold < bp_len) begin
          out_ready = 1'b0;
          hold++;
          chk("bp_data", out_data, outq[0].data);
          chk("bp_addr", out_addr, outq[0].addr);
          chk("bp_rd_en", rd_en, 0);
        end else begin
          out_ready = 1'b1;
          e = outq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_addr", out_addr, e.addr);
          n_acc++;
          acc_i = i;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        if (n_exp == 0) chk("done_degenerate", i, 1);
        else            chk("done_latency", i, acc_i + 1);
        fin = 1'b1;
      end
    end
    if (!fin) chk("timeout_done", 0, 1);
    chk("reads_left", rdq.size(), 0);
    chk("outs_left", outq.size(), 0);
    chk("accepted", n_acc, n_exp);
    @(negedge clk);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 16; k++) mem[16'h0100 + 16'(k)] = 16'(k);
    run_plane(4, 4, 16'h0100, 16'h0200, -1, 0, 1'b0, 0);

    for (int k = 0; k < 15; k++) mem[16'h0300 + 16'(k)] = 16'(k);
    run_plane(5, 3, 16'h0300, 16'h0400, -1, 0, 1'b0, 0);

    run_plane(4, 4, 16'h0100, 16'h0200, 1, 7, 1'b0, 0);

    mem[16'h0500] = 16'hFFFF; mem[16'h0501] = 16'h0001; mem[16'h0502] = 16'd3; mem[16'h0503] = 16'd3;
    mem[16'h0504] = 16'h7FFF; mem[16'h0505] = 16'h8000; mem[16'h0506] = 16'd3; mem[16'h0507] = 16'd3;
    run_plane(4, 2, 16'h0500, 16'h0600, -1, 0, 1'b0, 0);

    run_plane(1, 8, 16'h0100, 16'h0200, -1, 0, 1'b0, 0);

    run_plane(4, 4, 16'h0100, 16'h0200, -1, 0, 1'b1, 0);

    run_plane(4, 4, 16'h0100, 16'h0200, -1, 0, 1'b0, 9);
    run_plane(4, 4, 16'h0100, 16'h0200, -1, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maxpool_2x2_ctrl.md
Name: maxpool_2x2_ctrl

Overview:
Sequencer for the 2x2 stride-2 max-pooling datapath in the CNN accelerator. On a start pulse it walks one single-channel feature map held in a source SRAM and fetches each 2x2 window. It reduces each window with the existing 4-input comparator tree and streams the results, with destination addresses, over a valid/ready interface towards the output buffer. One plane is processed per start; the host loops over channels.

Parameters:
DATA_W, 16, pixel width (unsigned)
ADDR_W, 16, SRAM word address width
DIM_W, 8, width of feature-map dimension fields

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
cfg_width  in  DIM_W  input map width W in pixels
cfg_height  in  DIM_W  input map height H in pixels
cfg_src_base  in  ADDR_W  address of pixel (0,0), row-major
cfg_dst_base  in  ADDR_W  address of output pixel (0,0)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at plane completion
rd_en  out  1  SRAM read strobe
rd_addr  out  ADDR_W  SRAM read address
rd_data  in  DATA_W  SRAM data, valid exactly 1 cycle after rd_en
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  pooled max
out_addr  out  ADDR_W  destination address

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, rd_en, out_valid = 0; rd_addr, out_data, out_addr, counters and window regs = 0. Reset mid-operation aborts the plane with no done pulse.
- cfg_* values are latched on the accepted start and ignored afterwards. start outside IDLE is ignored.
- Output dims: OW = floor(W/2), OH = floor(H/2). An odd trailing row or column is never read.
- If W<2 or H<2: IDLE -> DONE, no reads, no outputs; done pulses the cycle after start.
- FSM states:
  - IDLE: wait for start; on start -> READ.
  - READ: 4 cycles, rd_en=1, rd_addr = p, p+1, p+W, p+W+1, where p = src_base + 2*oy*W + 2*ox.
  - LAST: rd_en=0; captures the 4th read word.
  - OUT: out_valid=1; out_data/out_addr held stable until out_ready.
  - DONE: done=1 for one cycle -> IDLE.
- Window capture: rd_data is registered into window slots 0..3 on the cycle after each read (READ cycles 2-4 and LAST).
- Reduction: out_data = max of the 4 slots via the comparator tree, unsigned >= compare. Registered on entry to OUT.
- Timing: READ entered at cycle t gives out_valid first high at t+5. Throughput without backpressure is 1 output per 6 cycles.
- Handshake:
  - OUT with out_ready=1 completes the transfer that cycle.
  - If it was not the last output -> READ next cycle; if it was the last (ox=OW-1, oy=OH-1) -> DONE.
  - out_ready during other states is ignored.
  - Once out_valid is high it never drops before acceptance.
- Address generation is incremental, with no multipliers:
  - p += 2 per window.
  - At end of row, row_base += 2*W and p = row_base.
  - out_addr starts at dst_base and increments by 1 per accepted output.
  - All address arithmetic wraps modulo 2^ADDR_W.
- busy = (state != IDLE). done and out_valid are never high in the same cycle.

Decomposition:
- Package maxpool_pkg: state enum (IDLE, READ, LAST, OUT, DONE), DATA_W/ADDR_W/DIM_W defaults, window slot index type.
- Sub-module maxpool_addr_gen: holds p, row_base, ox/oy counters and out_addr.
  - Inputs: init, step_read (0..3 phase), advance_window.
  - Outputs: rd_addr, out_addr, last_window.
- The existing 2x2 comparator tree is instantiated unchanged for the reduction.

Test Plan:
- 4x4 map, mem[src_base+i]=i, src_base=0x100, dst_base=0x200, out_ready=1 -> outputs (5,0x200), (7,0x201), (13,0x202), (15,0x203), then done one cycle after the last accept; first out_valid 6 cycles after start.
- 5x3 map, values 0..14 -> OW=2, OH=1; outputs 6 then 8; column 4 and row 2 never appear on rd_addr.
- Backpressure: 4x4 map, out_ready low for 7 cycles on the 2nd output -> out_valid, out_data=7 and out_addr=0x201 stay stable; no rd_en until the accept.
- Unsigned and tie windows: {0xFFFF,0x0001,0x7FFF,0x8000} -> 0xFFFF; {3,3,3,3} -> 3.
- Degenerate W=1, H=8 -> zero reads and zero outputs; done pulses 1 cycle after start. A start pulse while busy on a 4x4 run is ignored and the run is unchanged.
- Assert rst_n=0 during the 3rd READ cycle of window 2 -> all outputs 0 immediately; a fresh start after release reruns the full 4x4 plane correctly.
